controle_reg7b: RTL and testbench
=================================

# controle_reg7b

Mode controller that drives the select lines (`ch1`, `ch0`) and the load/shift enable of the 7-bit universal shift register built from the per-bit select-mux slices. It takes raw user commands (load, shift left, shift right, stop), synchronises them and detects their edges, then runs a four-state mode FSM. A programmable tick divider sets the shift rate. It is the initiator for the mux slices: it produces the select codes they decode and guarantees only legal codes reach them.

## Interface
- `DIV`, default 25_000_000: clock cycles per shift tick; legal range 2..2^26-1.
- `clock` in 1: system clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_carregar` in 1: load command, asynchronous level, active-high.
- `cmd_esq` in 1: start shifting right-to-left (select 01), asynchronous, active-high.
- `cmd_dir` in 1: start shifting left-to-right (select 10), asynchronous, active-high.
- `cmd_parar` in 1: stop/hold command, asynchronous, active-high.
- `ch1` out 1: mux select MSB.
- `ch0` out 1: mux select LSB.
- `en_reg` out 1: clock enable for the 7 register flip-flops; register updates only when high.
- `estado` out 2: current mode: 00 PARADO, 01 DESL_ESQ, 10 DESL_DIR, 11 CARREGA.

## Operation
- Each `cmd_*` passes a 2-FF synchroniser, then rising-edge detect (1-cycle pulse). Held levels do not retrigger.
- Same-cycle pulse priority: parar > carregar > esq > dir. Lower-priority pulses that cycle are dropped.
- States:
  - PARADO: `en_reg`=0, `ch1`/`ch0` hold their last value. Exits on carregar→CARREGA, esq→DESL_ESQ, dir→DESL_DIR.
  - CARREGA: exactly one cycle, `ch1ch0`=00, `en_reg`=1, then unconditionally PARADO. Command pulses arriving in this cycle are dropped.
  - DESL_ESQ: `ch1ch0`=01; `en_reg`=1 for one cycle on each tick. Parar→PARADO, carregar→CARREGA, dir→DESL_DIR, esq→no change.
  - DESL_DIR: `ch1ch0`=10; symmetric to DESL_ESQ.
- Select code 11 is never driven: `ch1`&`ch0`=1 is illegal in every cycle.
- Tick divider:
  - 26-bit counter, runs only in DESL_ESQ/DESL_DIR.
  - Counts 0..DIV-1; tick asserted when count = DIV-1, then wraps to 0.
  - Counter clears to 0 on every state entry, including a direction reversal.
- `en_reg` is the only enable source for the register. PARADO produces hold by deasserting `en_reg`, not through a select code.
- Outputs are registered; no combinational path from `cmd_*` to any output.

## Timing
- Reset (async assert, sync use after deassert): state PARADO, `ch1`=0, `ch0`=0, `en_reg`=0, `estado`=00, divider=0, sync/edge flops=0.
- A command rising edge at the input appears as a state/output change 4 clock edges later: 2 sync, 1 edge register, 1 state register.
- Load: `en_reg` is high for exactly 1 cycle, with `ch1ch0`=00 in that same cycle.
- Shift: first `en_reg` pulse DIV cycles after entering the shift state, then one pulse every DIV cycles. The selects are stable for at least 1 cycle before and during every `en_reg` pulse.
- Direction reversal: selects change in the entry cycle and `en_reg` is 0 in that cycle, so no shift occurs with a stale code.
- A reset in mid-shift or mid-load aborts immediately. `en_reg` drops asynchronously.

## Test plan
- Reset: hold `reset_n`=0 for 5 cycles → `ch1ch0`=00, `en_reg`=0, `estado`=00. Release → outputs unchanged.
- Load: pulse `cmd_carregar` for 3 cycles → 4 edges later `estado`=11 for 1 cycle with `en_reg`=1 and `ch1ch0`=00, then `estado`=00 and `en_reg`=0. Exactly one enable pulse.
- Shift rate (DIV=4): assert `cmd_esq` → `ch1ch0`=01, and `en_reg` pulses every 4th cycle. Count exactly 5 pulses in 20 cycles. Never `ch1ch0`=11.
- Reversal: during DESL_ESQ with DIV=4, 2 cycles after a tick, pulse `cmd_dir` → `ch1ch0`=10, and the next `en_reg` comes 4 cycles after entry, not 2.
- Priority: raise `cmd_parar` and `cmd_dir` on the same cycle from DESL_ESQ → `estado`=00, `ch1ch0` stays 01, `en_reg`=0 thereafter.
- Async reset mid-shift: drop `reset_n` between clock edges in DESL_DIR → `en_reg`=0 and `estado`=00 before the next edge. After release, no shift until a new command.

Source files
------------

// File: rtl/controle_reg7b.sv
// Mode controller for the 7-bit universal shift register: synchronises user
// commands, runs the load/shift/stop FSM and paces shifts with a tick divider.
module controle_reg7b #(
  parameter int unsigned DIV = 25_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_carregar,
  input  logic       cmd_esq,
  input  logic       cmd_dir,
  input  logic       cmd_parar,
  output logic       ch1,
  output logic       ch0,
  output logic       en_reg,
  output logic [1:0] estado
);

  localparam int unsigned CNT_W = 26;
  localparam int unsigned N_CMD = 4;

  localparam int unsigned I_DIR = 0;
  localparam int unsigned I_ESQ = 1;
  localparam int unsigned I_CAR = 2;
  localparam int unsigned I_PAR = 3;

  localparam logic [1:0] PARADO   = 2'b00;
  localparam logic [1:0] DESL_ESQ = 2'b01;
  localparam logic [1:0] DESL_DIR = 2'b10;
  localparam logic [1:0] CARREGA  = 2'b11;

  localparam logic [1:0] SEL_LOAD = 2'b00;
  localparam logic [1:0] SEL_ESQ  = 2'b01;
  localparam logic [1:0] SEL_DIR  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [N_CMD-1:0] cmd_raw;
  logic [N_CMD-1:0] sync1_q;
  logic [N_CMD-1:0] sync2_q;
  logic [N_CMD-1:0] sync3_q;
  logic [N_CMD-1:0] pulse_q;

  logic [1:0]       state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic p_par, p_car, p_esq, p_dir;
  logic tick;

  assign cmd_raw = {cmd_parar, cmd_carregar, cmd_esq, cmd_dir};

  // Two-flop synchroniser followed by a registered rising-edge detector
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      pulse_q <= '0;
    end else begin
      sync1_q <= cmd_raw;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      pulse_q <= sync2_q & ~sync3_q;
    end
  end

  assign p_par = pulse_q[I_PAR];
  assign p_car = pulse_q[I_CAR];
  assign p_esq = pulse_q[I_ESQ];
  assign p_dir = pulse_q[I_DIR];
  assign tick  = (cnt_q == CNT_LAST);

  // State, selects, enable and divider are all registered together
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PARADO;
      sel_q   <= SEL_LOAD;
      en_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state selection with parar > carregar > esq > dir priority
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PARADO: begin
        if (p_car)      state_d = CARREGA;
        else if (p_esq) state_d = DESL_ESQ;
        else if (p_dir) state_d = DESL_DIR;
      end
      CARREGA: state_d = PARADO;
      DESL_ESQ: begin
        if (p_par)      state_d = PARADO;
        else if (p_car) state_d = CARREGA;
        else if (p_dir) state_d = DESL_DIR;
      end
      DESL_DIR: begin
        if (p_par)      state_d = PARADO;
        else if (p_car) state_d = CARREGA;
        else if (p_esq) state_d = DESL_ESQ;
      end
      default: state_d = PARADO;
    endcase
  end

  // Outputs for the upcoming state; the divider restarts on every state entry
  always_comb begin
    sel_d = sel_q;
    en_d  = 1'b0;
    cnt_d = '0;
    unique case (state_d)
      CARREGA: begin
        sel_d = SEL_LOAD;
        en_d  = 1'b1;
      end
      DESL_ESQ: begin
        sel_d = SEL_ESQ;
        if (state_q == DESL_ESQ) begin
          en_d  = tick;
          cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
      end
      DESL_DIR: begin
        sel_d = SEL_DIR;
        if (state_q == DESL_DIR) begin
          en_d  = tick;
          cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
      end
      default: begin
        sel_d = sel_q;
        en_d  = 1'b0;
        cnt_d = '0;
      end
    endcase
  end

  assign ch1    = sel_q[1];
  assign ch0    = sel_q[0];
  assign en_reg = en_q;
  assign estado = state_q;

endmodule

// File: tb/tb_controle_reg7b.sv
// Scoreboard bench for controle_reg7b with a short divider (DIV=4).
module tb_controle_reg7b;

  localparam int unsigned DIV = 4;

  logic       clock;
  logic       reset_n;
  logic       cmd_carregar, cmd_esq, cmd_dir, cmd_parar;
  logic       ch1, ch0, en_reg;
  logic [1:0] estado;

  typedef struct {
    logic [1:0] est;
    logic [1:0] ch;
    logic       en;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  controle_reg7b #(.DIV(DIV)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cmd_carregar (cmd_carregar),
    .cmd_esq      (cmd_esq),
    .cmd_dir      (cmd_dir),
    .cmd_parar    (cmd_parar),
    .ch1          (ch1),
    .ch0          (ch0),
    .en_reg       (en_reg),
    .estado       (estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [1:0] e, input logic [1:0] c, input logic en);
    exp_t x;
    x.est = e; x.ch = c; x.en = en;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    exp_t x;
    int   i;
    reset_n = 1'b0;
    cmd_carregar = 0; cmd_esq = 0; cmd_dir = 0; cmd_parar = 0;
    repeat (5) step();
    n_cmp++;
    if ({estado, ch1, ch0, en_reg} !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_hold: got est=%b ch=%b%b en=%b, expected 00/00/0", estado, ch1, ch0, en_reg);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) push(2'b00, 2'b00, 1'b0);
    i = 0;
    while (sb.size() > 0) begin
      step(); i++;
      x = sb.pop_front();
      n_cmp++;
      if ({estado, ch1, ch0, en_reg} !== {x.est, x.ch, x.en}) begin
        n_err++;
        $display("FAIL reset_release cyc %0d: got %b/%b%b/%b, expected %b/%b/%b", i, estado, ch1, ch0, en_reg, x.est, x.ch, x.en);
      end
    end
  endtask

  task automatic test_load();
    exp_t x;
    int   i, pulses;
    for (int k = 1; k <= 6; k++)
      if (k == 4) push(2'b11, 2'b00, 1'b1);
      else        push(2'b00, 2'b00, 1'b0);
    cmd_carregar = 1'b1;
    i = 0; pulses = 0;
    while (sb.size() > 0) begin
      step(); i++;
      if (i == 3) cmd_carregar = 1'b0;
      if (en_reg === 1'b1) pulses++;
      x = sb.pop_front();
      n_cmp++;
      if ({estado, ch1, ch0, en_reg} !== {x.est, x.ch, x.en}) begin
        n_err++;
        $display("FAIL load cyc %0d: got %b/%b%b/%b, expected %b/%b/%b", i, estado, ch1, ch0, en_reg, x.est, x.ch, x.en);
      end
    end
    n_cmp++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL load_pulses: got %0d, expected 1", pulses);
    end
  endtask

  task automatic test_shift();
    exp_t x;
    int   i, k, pulses;
    for (int c = 1; c <= 24; c++) begin
      k = c - 4;
      if (k < 0) push(2'b00, 2'b00, 1'b0);
      else       push(2'b01, 2'b01, (k > 0) && (k % DIV == 0));
    end
    cmd_esq = 1'b1;
    i = 0; pulses = 0;
    while (sb.size() > 0) begin
      step(); i++;
      if (i == 6) cmd_esq = 1'b0;
      if (i >= 5 && en_reg === 1'b1) pulses++;
      n_cmp++;
      if ((ch1 & ch0) !== 1'b0) begin
        n_err++;
        $display("FAIL shift_illegal_sel cyc %0d: got ch=%b%b, expected not 11", i, ch1, ch0);
      end
      x = sb.pop_front();
      n_cmp++;
      if ({estado, ch1, ch0, en_reg} !== {x.est, x.ch, x.en}) begin
        n_err++;
        $display("FAIL shift cyc %0d: got %b/%b%b/%b, expected %b/%b/%b", i, estado, ch1, ch0, en_reg, x.est, x.ch, x.en);
      end
    end
    n_cmp++;
    if (pulses != 5) begin
      n_err++;
      $display("FAIL shift_pulses: got %0d in 20 cycles, expected 5", pulses);
    end
  endtask

  task automatic test_reversal();
    exp_t x;
    int   i, w;
    w = 0;
    while (en_reg !== 1'b1 && w < 3 * DIV) begin
      step(); w++;
    end
    n_cmp++;
    if (en_reg !== 1'b1) begin
      n_err++;
      $display("FAIL reversal_wait_tick: got en=%b after %0d cycles, expected 1", en_reg, w);
    end
    step(); step();
    cmd_dir = 1'b1;
    // Relative to the observed tick T: old tick at T+4, entry at T+6, next tick T+10
    push(2'b01, 2'b01, 1'b0);
    push(2'b01, 2'b01, 1'b1);
    push(2'b01, 2'b01, 1'b0);
    for (int c = 6; c <= 13; c++) push(2'b10, 2'b10, c == 10);
    i = 2;
    while (sb.size() > 0) begin
      step(); i++;
      if (i == 8) cmd_dir = 1'b0;
      x = sb.pop_front();
      n_cmp++;
      if ({estado, ch1, ch0, en_reg} !== {x.est, x.ch, x.en}) begin
        n_err++;
        $display("FAIL reversal T+%0d: got %b/%b%b/%b, expected %b/%b/%b", i, estado, ch1, ch0, en_reg, x.est, x.ch, x.en);
      end
    end
  endtask

  task automatic test_priority();
    exp_t x;
    int   i;
    cmd_esq = 1'b1;
    repeat (3) step();
    for (int c = 4; c <= 7; c++)  push(2'b01, 2'b01, 1'b0);
    for (int c = 8; c <= 15; c++) push(2'b00, 2'b01, 1'b0);
    i = 3;
    while (sb.size() > 0) begin
      step(); i++;
      if (i == 4) begin
        cmd_esq   = 1'b0;
        cmd_parar = 1'b1;
        cmd_dir   = 1'b1;
      end
      if (i == 10) begin
        cmd_parar = 1'b0;
        cmd_dir   = 1'b0;
      end
      x = sb.pop_front();
      n_cmp++;
      if ({estado, ch1, ch0, en_reg} !== {x.est, x.ch, x.en}) begin
        n_err++;
        $display("FAIL priority cyc %0d: got %b/%b%b/%b, expected %b/%b/%b", i, estado, ch1, ch0, en_reg, x.est, x.ch, x.en);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t x;
    int   i, w;
    cmd_dir = 1'b1;
    w = 0;
    while (en_reg !== 1'b1 && w < 4 * DIV + 8) begin
      step(); w++;
    end
    n_cmp++;
    if ({estado, ch1, ch0, en_reg} !== 5'b10101) begin
      n_err++;
      $display("FAIL async_pre_state: got %b/%b%b/%b after %0d cycles, expected 10/10/1", estado, ch1, ch0, en_reg, w);
    end
    #2;
    reset_n = 1'b0;
    cmd_dir = 1'b0;
    #1;
    n_cmp++;
    if ({estado, ch1, ch0, en_reg} !== 5'b00000) begin
      n_err++;
      $display("FAIL async_reset_drop: got %b/%b%b/%b, expected 00/00/0", estado, ch1, ch0, en_reg);
    end
    repeat (3) step();
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) push(2'b00, 2'b00, 1'b0);
    i = 0;
    while (sb.size() > 0) begin
      step(); i++;
      x = sb.pop_front();
      n_cmp++;
      if ({estado, ch1, ch0, en_reg} !== {x.est, x.ch, x.en}) begin
        n_err++;
        $display("FAIL async_after_release cyc %0d: got %b/%b%b/%b, expected %b/%b/%b", i, estado, ch1, ch0, en_reg, x.est, x.ch, x.en);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_shift();
    test_reversal();
    test_priority();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
